multiphase_clock_gen: RTL



---
 rtl/multiphase_clock_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/multiphase_clock_gen.sv
// One-hot multiphase enable generator with run/drain control and end-of-rotation strobe.
// Optional single-rotation step mode is compiled in when MULTIPHASE_STEP_EN is defined.
module multiphase_clock_gen #(
   parameter int PHASES = 4,
   parameter int HOLD   = 1
) (
   input  logic                                                  clkIn,
   input  logic                                                  reset,
   input  logic                                                  run,
   input  logic                                                  stepReq,
   output logic [PHASES-1:0]                                     phaseOut,
   output logic [(($clog2(PHASES) > 1) ? $clog2(PHASES) : 1)-1:0] phaseIdx,
   output logic                                                  cycleDone,
   output logic                                                  running
);

   localparam int IW = ($clog2(PHASES) > 1) ? $clog2(PHASES) : 1;
   localparam int HW = ($clog2(HOLD) > 1) ? $clog2(HOLD) : 1;
   localparam logic [IW-1:0] LAST_PH   = IW'(PHASES - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_t;

   state_t            state_reg;
   logic [IW-1:0]     phase_reg;
   logic [HW-1:0]     hold_reg;

   logic              at_last;
   logic              start_req;
   logic [IW-1:0]     adv_phase;
   logic [HW-1:0]     adv_hold;
   logic              adv_done;
   logic [PHASES-1:0] adv_onehot;

`ifdef MULTIPHASE_STEP_EN
   assign start_req = run | stepReq;
`else
   logic step_unused;
   assign step_unused = stepReq;
   assign start_req   = run;
`endif

   // Position one clock ahead, used both to advance and to pre-register the outputs.
   always_comb begin
      at_last   = (phase_reg == LAST_PH) && (hold_reg == LAST_HOLD);
      adv_phase = phase_reg;
      adv_hold  = hold_reg + HW'(1);
      if (hold_reg == LAST_HOLD) begin
         adv_hold  = '0;
         adv_phase = (phase_reg == LAST_PH) ? '0 : phase_reg + IW'(1);
      end
      adv_done   = (adv_phase == LAST_PH) && (adv_hold == LAST_HOLD);
      adv_onehot = PHASES'(1) << adv_phase;
   end

   always_ff @(posedge clkIn) begin
      if (reset) begin
         state_reg <= IDLE;
         phase_reg <= '0;
         hold_reg  <= '0;
         phaseOut  <= '0;
         phaseIdx  <= '0;
         cycleDone <= 1'b0;
         running   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (run) begin
                  state_reg <= RUN;
`ifdef MULTIPHASE_STEP_EN
               end else if (stepReq) begin
                  state_reg <= STEP;
`endif
               end
            end
            RUN: begin
               if (!run) state_reg <= at_last ? IDLE : DRAIN;
            end
            DRAIN: begin
               if (run) state_reg <= RUN;
               else if (at_last) state_reg <= IDLE;
            end
`ifdef MULTIPHASE_STEP_EN
            STEP: begin
               if (run) state_reg <= RUN;
               else if (at_last) state_reg <= IDLE;
            end
`endif
            default: state_reg <= IDLE;
         endcase

         if (state_reg == IDLE) begin
            // Phase 0 is never the last phase, so a start never raises cycleDone.
            phase_reg <= '0;
            hold_reg  <= '0;
            phaseIdx  <= '0;
            cycleDone <= 1'b0;
            phaseOut  <= start_req ? PHASES'(1) : '0;
            running   <= start_req;
         end else if (at_last && !run) begin
            phase_reg <= '0;
            hold_reg  <= '0;
            phaseOut  <= '0;
            phaseIdx  <= '0;
            cycleDone <= 1'b0;
            running   <= 1'b0;
         end else begin
            phase_reg <= adv_phase;
            hold_reg  <= adv_hold;
            phaseOut  <= adv_onehot;
            phaseIdx  <= adv_phase;
            cycleDone <= adv_done;
            running   <= 1'b1;
         end
      end
   end

endmodule
